// File: rtl/mac_matrix_ctrl_if.sv
// Bus bundle between mac_matrix_ctrl and its weight buffer, activation/result streams and MAC matrix.
// master = controller side, slave = surrounding environment.
interface mac_matrix_ctrl_if #(
  parameter int DATA_SIZE = 8,
  parameter int MAC_WIDTH = 8
);
  localparam int AW = (MAC_WIDTH > 1) ? $clog2(MAC_WIDTH) : 1;
  localparam int VW = MAC_WIDTH * DATA_SIZE;

  logic                           start;
  logic [7:0]                     vec_count;
  logic                           busy;
  logic                           done;
  logic                           wbuf_rd_en;
  logic [AW-1:0]                  wbuf_rd_addr;
  logic [VW-1:0]                  wbuf_rd_data;
  logic                           act_valid;
  logic                           act_ready;
  logic [VW-1:0]                  act_data;
  logic                           res_valid;
  logic [VW-1:0]                  res_data;
  logic                           instr;
  logic [MAC_WIDTH*MAC_WIDTH-1:0] weights_request;
  logic [MAC_WIDTH*VW-1:0]        weights_data;
  logic [VW-1:0]                  values_in1;
  logic [VW-1:0]                  values_in2;
  logic [VW-1:0]                  values_out1;

  modport master (
    input  start, vec_count, wbuf_rd_data, act_valid, act_data, weights_request, values_out1,
    output busy, done, wbuf_rd_en, wbuf_rd_addr, act_ready, res_valid, res_data, instr,
           weights_data, values_in1, values_in2
  );

  modport slave (
    output start, vec_count, wbuf_rd_data, act_valid, act_data, weights_request, values_out1,
    input  busy, done, wbuf_rd_en, wbuf_rd_addr, act_ready, res_valid, res_data, instr,
           weights_data, values_in1, values_in2
  );
endinterface

// File: rtl/mac_matrix_ctrl.sv
// Systolic MAC matrix sequencer: loads a weight tile, commits it, then streams skewed activations
// into the matrix and deskews the bottom-edge outputs into aligned result vectors.
module mac_matrix_ctrl #(
  parameter int DATA_SIZE = 8,
  parameter int MAC_WIDTH = 8,
  parameter int ARRAY_LAT = 8
) (
  input  logic              clock,
  input  logic              reset,
  mac_matrix_ctrl_if.master bus
);
  localparam int AW   = (MAC_WIDTH > 1) ? $clog2(MAC_WIDTH) : 1;
  localparam int CW   = $clog2(MAC_WIDTH + 1);
  localparam int VW   = MAC_WIDTH * DATA_SIZE;
  localparam int TAGN = ARRAY_LAT + MAC_WIDTH + 1;

  typedef enum logic [2:0] {IDLE, WLOAD, WCOMMIT, STREAM, DRAIN, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [CW-1:0]          rd_cnt_reg;
  logic                   cap_valid_reg;
  logic [AW-1:0]          cap_row_reg;
  logic [7:0]             remain_reg;
  logic [TAGN-1:0]        tag_reg;
  logic                   rd_en;
  logic                   handshake;
  logic                   last_row;
  logic                   wcap;
  logic [VW-1:0]          inject;
  logic [MAC_WIDTH*VW-1:0] weights_flat;
  logic [VW-1:0]          vin_flat;
  logic [VW-1:0]          res_flat;

  assign rd_en     = (state_reg == WLOAD) && (rd_cnt_reg < CW'(MAC_WIDTH));
  assign handshake = (state_reg == STREAM) && bus.act_valid;
  assign wcap      = (state_reg == WLOAD) && cap_valid_reg;
  assign last_row  = wcap && (cap_row_reg == AW'(MAC_WIDTH - 1));
  // Cycles without an accepted vector feed zeros so the matrix sees clean bubbles.
  assign inject    = handshake ? bus.act_data : '0;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = WLOAD;
      WLOAD:   if (last_row) state_next = WCOMMIT;
      WCOMMIT: if (bus.weights_request == '0)
                 state_next = (remain_reg == 8'd0) ? DONE : STREAM;
      STREAM:  if (handshake && (remain_reg == 8'd1)) state_next = DRAIN;
      DRAIN:   if (tag_reg[TAGN-1] && (tag_reg[TAGN-2:0] == '0)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      rd_cnt_reg    <= '0;
      cap_valid_reg <= 1'b0;
      cap_row_reg   <= '0;
      remain_reg    <= 8'd0;
      tag_reg       <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE) begin
        rd_cnt_reg <= '0;
      end else if (rd_en) begin
        rd_cnt_reg <= rd_cnt_reg + CW'(1);
      end
      // Buffer data lags the strobe by one cycle; remember which row is arriving.
      cap_valid_reg <= rd_en;
      cap_row_reg   <= rd_cnt_reg[AW-1:0];
      if ((state_reg == IDLE) && bus.start) begin
        remain_reg <= bus.vec_count;
      end else if (handshake) begin
        remain_reg <= remain_reg - 8'd1;
      end
      tag_reg <= {tag_reg[TAGN-2:0], handshake};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < MAC_WIDTH; gi++) begin : g_row
      logic [VW-1:0]        wrow_reg;
      logic [DATA_SIZE-1:0] skew_reg [gi+1];

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          wrow_reg <= '0;
        end else if (wcap && (cap_row_reg == AW'(gi))) begin
          wrow_reg <= bus.wbuf_rd_data;
        end
      end
      assign weights_flat[gi*VW +: VW] = wrow_reg;

      // Row gi enters the left edge gi cycles after row 0.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int k = 0; k <= gi; k++) skew_reg[k] <= '0;
        end else begin
          skew_reg[0] <= inject[gi*DATA_SIZE +: DATA_SIZE];
          for (int k = 1; k <= gi; k++) skew_reg[k] <= skew_reg[k-1];
        end
      end
      assign vin_flat[gi*DATA_SIZE +: DATA_SIZE] = skew_reg[gi];
    end

    for (gi = 0; gi < MAC_WIDTH; gi++) begin : g_col
      localparam int DD = MAC_WIDTH - 1 - gi;
      logic [DATA_SIZE-1:0] col_in;
      logic [DATA_SIZE-1:0] res_lane_reg;

      if (DD == 0) begin : g_nodly
        assign col_in = bus.values_out1[gi*DATA_SIZE +: DATA_SIZE];
      end else begin : g_dly
        logic [DATA_SIZE-1:0] dly_reg [DD];
        always_ff @(posedge clock or posedge reset) begin
          if (reset) begin
            for (int k = 0; k < DD; k++) dly_reg[k] <= '0;
          end else begin
            dly_reg[0] <= bus.values_out1[gi*DATA_SIZE +: DATA_SIZE];
            for (int k = 1; k < DD; k++) dly_reg[k] <= dly_reg[k-1];
          end
        end
        assign col_in = dly_reg[DD-1];
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          res_lane_reg <= '0;
        end else begin
          res_lane_reg <= col_in;
        end
      end
      assign res_flat[gi*DATA_SIZE +: DATA_SIZE] = res_lane_reg;
    end
  endgenerate

  assign bus.busy         = (state_reg != IDLE) && (state_reg != DONE);
  assign bus.done         = (state_reg == DONE);
  assign bus.wbuf_rd_en   = rd_en;
  assign bus.wbuf_rd_addr = rd_en ? rd_cnt_reg[AW-1:0] : '0;
  assign bus.act_ready    = (state_reg == STREAM);
  assign bus.instr        = (state_reg == WCOMMIT);
  assign bus.res_valid    = tag_reg[TAGN-1];
  assign bus.res_data     = res_flat;
  assign bus.weights_data = weights_flat;
  assign bus.values_in1   = vin_flat;
  assign bus.values_in2   = '0;

endmodule
